// File: rtl/req_rep_checker_if.sv
// Request-run checker bus: the monitored request and clear, plus the checker's result outputs.
// The checker takes the slave modport and the stimulus side takes the master modport.
interface req_rep_checker_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req;
  logic             clr;
  logic             busy;
  logic             pass;
  logic             fail;
  logic [1:0]       fail_code;
  logic [3:0]       len;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output req, clr,
    input  busy, pass, fail, fail_code, len, pass_cnt, fail_cnt
  );

  modport slave (
    input  req, clr,
    output busy, pass, fail, fail_code, len, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/req_rep_checker.sv
// Measures each high run of req and pulses pass/fail depending on whether its length is legal.
// Define REQ_REP_CNT_EN to build the saturating pass/fail event counters; otherwise they read as 0.
module req_rep_checker #(
  parameter int unsigned MIN_LEN = 3,
  parameter int unsigned MAX_LEN = 5,
  parameter int unsigned CNT_W   = 8
) (
  input logic              clk,
  input logic              rst_n,
  req_rep_checker_if.slave bus
);

  localparam int unsigned LEN_W = 4;
  localparam logic [LEN_W-1:0] MIN_L  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] OVER_L = LEN_W'(MAX_LEN + 1);
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_SHORT = 2'b01;
  localparam logic [1:0] CODE_OVER  = 2'b10;

  typedef enum logic [1:0] {IDLE, HOLD, OVER} state_e;

  state_e           state_q, state_d;
  logic             req_q;
  logic [LEN_W-1:0] run_q, run_d, run_inc;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       code_q, code_d;
  logic [LEN_W-1:0] len_q, len_d;

  assign run_inc = run_q + LEN_W'(1);

  // Next-state and result decode; req_q starts at 1 so a level already high is never a rise.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pass_d  = 1'b0;
    fail_d  = 1'b0;
    code_d  = CODE_NONE;
    len_d   = len_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req && !req_q) begin
          run_d   = LEN_W'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.req) begin
          run_d = run_inc;
          if (run_inc == OVER_L) begin
            fail_d  = 1'b1;
            code_d  = CODE_OVER;
            len_d   = OVER_L;
            state_d = OVER;
          end
        end else begin
          len_d   = run_q;
          state_d = IDLE;
          if (run_q >= MIN_L) begin
            pass_d = 1'b1;
          end else begin
            fail_d = 1'b1;
            code_d = CODE_SHORT;
          end
        end
      end
      OVER: begin
        if (!bus.req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b1;
      run_q   <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= CODE_NONE;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= bus.req;
      run_q   <= run_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
      len_q   <= len_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.pass      = pass_q;
  assign bus.fail      = fail_q;
  assign bus.fail_code = code_q;
  assign bus.len       = len_q;

`ifdef REQ_REP_CNT_EN
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  // Saturating event counters; clear wins over a coincident event.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (bus.clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_d && !(&pass_cnt_q)) pass_cnt_d = pass_cnt_q + CNT_W'(1);
      if (fail_d && !(&fail_cnt_q)) fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign bus.pass_cnt = pass_cnt_q;
  assign bus.fail_cnt = fail_cnt_q;
`else
  logic unused_clr;
  assign unused_clr   = bus.clr;
  assign bus.pass_cnt = CNT_W'(0);
  assign bus.fail_cnt = CNT_W'(0);
`endif

endmodule

// File: doc/req_rep_checker.md
REQ_REP_CHECKER -- requirements
Module: req_rep_checker

Interface
REQ-001 Parameter MIN_LEN, default 3: minimum legal consecutive-high length of req, in clock samples.
REQ-002 Parameter MAX_LEN, default 5: maximum legal consecutive-high length of req, in clock samples.
REQ-003 Parameter CNT_W, default 8: width of the pass/fail event counters.
REQ-004 Parameters SHALL satisfy 1 <= MIN_LEN <= MAX_LEN <= 14, and CNT_W >= 1.
REQ-005 clk  input  1  single clock; all state updates on posedge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req  input  1  monitored request, sampled at posedge clk.
REQ-008 clr  input  1  synchronous clear of pass_cnt/fail_cnt.
REQ-009 busy  output  1  high while a request run is being measured (state HOLD or OVER).
REQ-010 pass  output  1  one-cycle pulse: run ended with length in [MIN_LEN, MAX_LEN].
REQ-011 fail  output  1  one-cycle pulse: run too short or too long.
REQ-012 fail_code  output  2  01 = SHORT, 10 = OVER, 00 otherwise; valid while fail is high.
REQ-013 len  output  4  measured run length, updated with every pass/fail pulse, held otherwise.
REQ-014 pass_cnt  output  CNT_W  count of pass events.
REQ-015 fail_cnt  output  CNT_W  count of fail events.

Function
REQ-016 Internal req_q SHALL hold the previous req sample; a rise is req=1 with req_q=0.
REQ-017 FSM states: IDLE, HOLD, OVER; all outputs registered.
REQ-018 IDLE: on rise, run length := 1 and go to HOLD; otherwise remain.
REQ-019 HOLD with req=1: run length increments; when it reaches MAX_LEN+1, issue fail with code OVER and len=MAX_LEN+1, then go to OVER.
REQ-020 HOLD with req=0: if run length >= MIN_LEN, issue pass; otherwise issue fail with code SHORT; set len to the run length; go to IDLE.
REQ-021 OVER: remain while req=1 with no further pulses; on req=0 go to IDLE silently.
REQ-022 pass/fail SHALL go high in the cycle after the deciding sample edge, for exactly one cycle, and never both at once.
REQ-023 A fall followed by a rise on the next sample SHALL end the current run and start a new one.
REQ-024 Counters SHALL saturate at all-ones, not wrap.
REQ-025 clr has priority: when clr coincides with an event, counters become 0, while the pass/fail pulse is still issued.

Reset
REQ-026 On rst_n low: state=IDLE, req_q=1, busy=0, pass=0, fail=0, fail_code=00, len=0, pass_cnt=0, fail_cnt=0.
REQ-027 Because req_q resets to 1, a req already high at reset release SHALL NOT be measured until it falls and rises again.
REQ-028 Reset mid-run SHALL abandon the run with no pulse.

Configuration
REQ-029 Macro REQ_REP_CNT_EN defined: pass_cnt/fail_cnt are implemented per REQ-014/015/024/025.
REQ-030 Macro REQ_REP_CNT_EN undefined: counter logic is omitted, pass_cnt/fail_cnt are tied to 0, and clr is ignored; the ports remain present.

Verification (MIN_LEN=3, MAX_LEN=5, REQ_REP_CNT_EN defined)
REQ-031 req high for 4 samples then low -> pass for one cycle after the low sample, len=4, pass_cnt=1, fail=0.
REQ-032 req high for 2 samples then low -> fail with fail_code=01 and len=2, fail_cnt=1.
REQ-033 req high for 8 samples -> one fail with fail_code=10 and len=6 after the 6th high sample, busy stays high until the fall, no pulse at the fall.
REQ-034 req high 3, low 1, high 5, low -> two passes, with len=3 then len=5, pass_cnt=2.
REQ-035 rst_n pulsed low during HOLD with req kept high -> all outputs 0, no pulse; after req falls and rises for 3 samples -> pass, len=3.
REQ-036 clr asserted in the same cycle as a pass event -> pass pulse seen, pass_cnt=0 afterwards; a 1-bit-counter saturation build with CNT_W=1 and three passes -> pass_cnt=1.
